// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
//   Front-end datapath definitions.
//   fetch_state_t   : fetch FSM states.
//   PC_STEP_DEFAULT : default sequential PC increment in bytes.
// -----------------------------------------------------------------------------
package datapath_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,  // request outstanding at pc_reg
        HOLD   = 2'd1,  // instruction held for the consumer
        DRAIN  = 2'd2,  // waiting out a request whose data will be dropped
        HALTED = 2'd3   // stopped until reset
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage : datapath_pkg

// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
//   Basic machine-word types shared across the core.
//   word_t : 32-bit architectural word (addresses, instructions).
// -----------------------------------------------------------------------------
package types_pkg;

    typedef logic [31:0] word_t;

endpackage : types_pkg

// File: rtl/fetch_pc_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if
//   Bundles the fetch_pc_unit signals.
//   Port    : CLK (clock shared with the block).
//   Modport fp : the fetch block's view (drives request/instruction outputs).
//   Modport tb : the environment's view (drives control, branch and memory).
// -----------------------------------------------------------------------------
interface fetch_pc_if (
    input logic CLK
);
    import types_pkg::*;

    logic  nRST;
    logic  branch_outcome;
    word_t updated_pc;
    logic  stall;
    logic  halt;
    logic  imem_ren;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;
    word_t current_pc;
    word_t instr_out;
    logic  instr_valid;
    logic  halted;

    modport fp (
        input  CLK, nRST, branch_outcome, updated_pc, stall, halt,
               imem_ready, imem_rdata,
        output imem_ren, imem_addr, current_pc, instr_out, instr_valid, halted
    );

    modport tb (
        input  CLK, imem_ren, imem_addr, current_pc, instr_out, instr_valid,
               halted,
        output nRST, branch_outcome, updated_pc, stall, halt, imem_ready,
               imem_rdata
    );

endinterface : fetch_pc_if

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter and single-outstanding-request instruction fetch.
//   Issues a read at pc_reg, registers the returned word for the decoder,
//   handles branch redirects (including while a request is in flight) and a
//   sticky halt.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   branch_outcome         taken-branch redirect strobe
//   updated_pc             redirect target (valid with branch_outcome)
//   stall                  consumer not ready; held instruction kept
//   halt                   stop fetching (wins over a redirect)
//   imem_ren, imem_addr    instruction memory request
//   imem_ready, imem_rdata memory completion and data
//   current_pc, instr_out  PC and word of the held instruction
//   instr_valid            held instruction valid
//   halted                 block is in HALTED
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import types_pkg::*;
    import datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        branch_outcome,
    input  logic [31:0] updated_pc,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] current_pc,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_t state;
    word_t        pc_reg;
    word_t        target;     // redirect target saved while draining
    logic         halt_pend;  // halt seen while a request or hold was pending

    // pc_reg only moves on completion or redirect, so the address stays
    // stable for the whole life of a request (including DRAIN).
    assign imem_ren  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = pc_reg;
    assign halted    = (state == HALTED);

    // NOTE: all state uses non-blocking assignments so every branch of the
    // case below sees the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc_reg      <= RESET_PC;
            target      <= '0;
            instr_out   <= '0;
            current_pc  <= '0;
            instr_valid <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        // Halt outranks any redirect; the in-flight request
                        // must still complete before stopping.
                        instr_valid <= 1'b0;
                        if (imem_ready) begin
                            state <= HALTED;
                        end else begin
                            halt_pend <= 1'b1;
                            state     <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (branch_outcome) begin
                            pc_reg      <= updated_pc;
                            instr_valid <= 1'b0;
                        end else begin
                            instr_out   <= imem_rdata;
                            current_pc  <= pc_reg;
                            instr_valid <= 1'b1;
                            pc_reg      <= pc_reg + word_t'(PC_STEP);
                            state       <= HOLD;
                        end
                    end else if (branch_outcome) begin
                        target      <= updated_pc;
                        instr_valid <= 1'b0;
                        state       <= DRAIN;
                    end
                end

                HOLD: begin
                    if (halt || halt_pend) begin
                        if (!stall) begin
                            instr_valid <= 1'b0;
                            state       <= HALTED;
                        end else begin
                            halt_pend <= 1'b1;
                        end
                    end else if (branch_outcome) begin
                        pc_reg      <= updated_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end

                DRAIN: begin
                    if (imem_ready) begin
                        if (halt || halt_pend) begin
                            state <= HALTED;
                        end else begin
                            // A redirect arriving with the completion is the
                            // latest one and takes precedence.
                            pc_reg <= branch_outcome ? updated_pc : target;
                            state  <= FETCH;
                        end
                    end else if (halt) begin
                        halt_pend <= 1'b1;
                    end else if (branch_outcome) begin
                        target <= updated_pc;
                    end
                end

                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed self-checking bench for fetch_pc_unit. A second instance with
//   RESET_PC = 0xFFFF_FFFC shares the inputs and covers address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    fetch_pc_if bus (.CLK(clk));

    int checks = 0;
    int errors = 0;

    logic        w_ren;
    logic [31:0] w_addr;
    logic [31:0] w_cpc;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_halted;

    fetch_pc_unit dut (
        .CLK            (clk),
        .nRST           (bus.nRST),
        .branch_outcome (bus.branch_outcome),
        .updated_pc     (bus.updated_pc),
        .stall          (bus.stall),
        .halt           (bus.halt),
        .imem_ren       (bus.imem_ren),
        .imem_addr      (bus.imem_addr),
        .imem_ready     (bus.imem_ready),
        .imem_rdata     (bus.imem_rdata),
        .current_pc     (bus.current_pc),
        .instr_out      (bus.instr_out),
        .instr_valid    (bus.instr_valid),
        .halted         (bus.halted)
    );

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK            (clk),
        .nRST           (bus.nRST),
        .branch_outcome (bus.branch_outcome),
        .updated_pc     (bus.updated_pc),
        .stall          (bus.stall),
        .halt           (bus.halt),
        .imem_ren       (w_ren),
        .imem_addr      (w_addr),
        .imem_ready     (bus.imem_ready),
        .imem_rdata     (bus.imem_rdata),
        .current_pc     (w_cpc),
        .instr_out      (w_instr),
        .instr_valid    (w_valid),
        .halted         (w_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of the main DUT outputs checked together.
    task automatic check_out(input string tag, input logic ren,
                             input logic [31:0] addr, input logic valid,
                             input logic hlt);
        check({tag, ".ren"},    32'(bus.imem_ren),    32'(ren));
        check({tag, ".addr"},   bus.imem_addr,        addr);
        check({tag, ".valid"},  32'(bus.instr_valid), 32'(valid));
        check({tag, ".halted"}, 32'(bus.halted),      32'(hlt));
    endtask

    initial begin
        bus.nRST           = 1'b0;
        bus.branch_outcome = 1'b0;
        bus.updated_pc     = '0;
        bus.stall          = 1'b0;
        bus.halt           = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.imem_rdata     = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_out("rst", 1'b1, 32'h0, 1'b0, 1'b0);
        check("rst.instr", bus.instr_out,  32'h0);
        check("rst.cpc",   bus.current_pc, 32'h0);
        check("rst.wrap_addr", w_addr, 32'hFFFF_FFFC);

        @(negedge clk);
        bus.nRST = 1'b1;
        #1;
        check_out("rel", 1'b1, 32'h0, 1'b0, 1'b0);

        // ---- sequential fetch 0x0 -> 0x4 -> 0x8 ----
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        tick();
        check_out("f0", 1'b0, 32'h4, 1'b1, 1'b0);
        check("f0.instr", bus.instr_out,  32'h1111_1111);
        check("f0.cpc",   bus.current_pc, 32'h0);
        check("wrap.addr", w_addr, 32'h0000_0000);
        check("wrap.cpc",  w_cpc,  32'hFFFF_FFFC);

        tick();
        check_out("c0", 1'b1, 32'h4, 1'b0, 1'b0);

        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check_out("f1", 1'b0, 32'h8, 1'b1, 1'b0);
        check("f1.instr", bus.instr_out,  32'hDEAD_BEEF);
        check("f1.cpc",   bus.current_pc, 32'h4);

        // ---- stall for 3 cycles in HOLD ----
        bus.stall      = 1'b1;
        bus.imem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall", 1'b0, 32'h8, 1'b1, 1'b0);
            check("stall.instr", bus.instr_out,  32'hDEAD_BEEF);
            check("stall.cpc",   bus.current_pc, 32'h4);
        end
        bus.stall = 1'b0;
        tick();
        check_out("unstall", 1'b1, 32'h8, 1'b0, 1'b0);

        // ---- redirect in HOLD ----
        bus.imem_rdata = 32'h2222_2222;
        tick();
        check_out("f2", 1'b0, 32'hC, 1'b1, 1'b0);
        check("f2.cpc", bus.current_pc, 32'h8);
        bus.branch_outcome = 1'b1;
        bus.updated_pc     = 32'h100;
        tick();
        check_out("redir_hold", 1'b1, 32'h100, 1'b0, 1'b0);

        // Redirect coinciding with a completion: response discarded.
        bus.updated_pc = 32'h8;
        bus.imem_rdata = 32'h6666_6666;
        tick();
        check_out("redir_rdy", 1'b1, 32'h8, 1'b0, 1'b0);
        check("redir_rdy.instr", bus.instr_out, 32'h2222_2222);

        // ---- redirect mid-request, latest target wins ----
        bus.branch_outcome = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.stall          = 1'b1;  // no effect outside HOLD
        tick();
        check_out("wait1", 1'b1, 32'h8, 1'b0, 1'b0);
        bus.branch_outcome = 1'b1;
        bus.updated_pc     = 32'h200;
        tick();
        check_out("drain1", 1'b1, 32'h8, 1'b0, 1'b0);
        bus.updated_pc = 32'h300;
        tick();
        check_out("drain2", 1'b1, 32'h8, 1'b0, 1'b0);
        bus.branch_outcome = 1'b0;
        tick();
        check_out("drain3", 1'b1, 32'h8, 1'b0, 1'b0);
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h3333_3333;
        tick();
        check_out("drained", 1'b1, 32'h300, 1'b0, 1'b0);
        check("drained.instr", bus.instr_out, 32'h2222_2222);

        // ---- halt with simultaneous redirect during FETCH ----
        bus.imem_ready     = 1'b0;
        bus.halt           = 1'b1;
        bus.branch_outcome = 1'b1;
        bus.updated_pc     = 32'h400;
        tick();
        check_out("halt_req", 1'b1, 32'h300, 1'b0, 1'b0);
        bus.halt           = 1'b0;
        bus.branch_outcome = 1'b0;
        bus.imem_ready     = 1'b1;
        tick();
        check_out("halted", 1'b0, 32'h300, 1'b0, 1'b1);
        check("halted.instr", bus.instr_out, 32'h2222_2222);
        bus.branch_outcome = 1'b1;
        bus.updated_pc     = 32'h500;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("halted_stay", 1'b0, 32'h300, 1'b0, 1'b1);
        end
        bus.branch_outcome = 1'b0;

        // ---- asynchronous reset between edges ----
        bus.nRST = 1'b0;
        #1;
        check_out("arst", 1'b1, 32'h0, 1'b0, 1'b0);
        check("arst.instr", bus.instr_out,  32'h0);
        check("arst.cpc",   bus.current_pc, 32'h0);
        @(negedge clk);
        bus.nRST = 1'b1;

        // ---- halt in HOLD waits for the consumer ----
        bus.imem_rdata = 32'h4444_4444;
        tick();
        check_out("h_f", 1'b0, 32'h4, 1'b1, 1'b0);
        check("h_f.instr", bus.instr_out, 32'h4444_4444);
        bus.halt  = 1'b1;
        bus.stall = 1'b1;
        tick();
        check_out("h_hold1", 1'b0, 32'h4, 1'b1, 1'b0);
        bus.halt = 1'b0;
        tick();
        check_out("h_hold2", 1'b0, 32'h4, 1'b1, 1'b0);
        bus.stall = 1'b0;
        tick();
        check_out("h_done", 1'b0, 32'h4, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_pc_unit
